riscv_core: RTL and testbench
=============================

Name: riscv_core

Overview:
- Self-contained RV32I-subset, 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
- Contains its own instruction ROM (preloaded program) and data RAM.
- Has no forwarding and no hazard interlock. Software (the ROM program) spaces dependent instructions with NOPs.
- Top-level CPU block of the design; its only I/O is clock and reset.

Parameters:
- IMEM_DEPTH, 64, instruction ROM depth in 32-bit words, word-indexed by PC[log2(IMEM_DEPTH)+1:2].
- DMEM_DEPTH, 64, data RAM depth in words.
- RESET_PC, 32'h0000_0000, PC value on reset.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  reset; asynchronous and active-low.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - PC=RESET_PC.
  - All pipeline registers hold a bubble (NOP, write-enable 0).
  - All 32 registers = 0.
- After reset release, fetch of ROM[0] begins on the first rising edge.
- Supported instructions:
  - LUI.
  - ADDI, ANDI, ORI, XORI, SLTI.
  - ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - LW, SW.
  - BEQ, BNE, JAL.
- Any other encoding executes as NOP: no register write, no memory write.
- NOP = 32'h0000_0013.
- Register file:
  - 32x32 array at hierarchical path decode_stage_inst.register_file_inst.registers[0..31]. This path is a verification interface and is fixed.
  - x0 reads 0 and is never written.
  - Two async read ports, one write port written on the rising clk in WB.
  - Same-cycle write and read of the same nonzero address returns the new data (internal write-through). Consequence: two instructions between producer and consumer suffice.
- Stage timing: an instruction fetched in cycle n is in ID at n+1, EX at n+2, MEM at n+3, and writes the register at the end of n+4.
- Immediates are sign-extended per RV32I format. All arithmetic is 32-bit, wraps modulo 2^32, with no overflow trap.
- Shift amount is rs2[4:0] (or imm[4:0]).
- SLT/SLTI are signed compares.
- Branches/JAL:
  - Resolved in EX.
  - When taken: PC <= target, and the two younger instructions (in IF/ID and ID/EX) are flushed to bubbles.
  - JAL writes PC+4 to rd.
  - Not taken: sequential fetch.
- Memory:
  - LW/SW use word-aligned addresses; the low two bits are ignored. Address wraps modulo DMEM_DEPTH.
  - SW writes on the clock edge at the end of MEM.
  - LW data is available in MEM and written back in WB.
  - Data RAM is not reset.
- PC past the end of the ROM wraps via the index bits. Unprogrammed ROM words are NOP.
- No hazard detection: a RAW dependency closer than 3 instructions reads the stale value. This is required behaviour, not an error.
- ROM program (word index: instruction):
  - 0: addi x1,x0,10
  - 1: addi x2,x0,10
  - 2–4: nop
  - 5: sub x4,x1,x2
  - 6: addi x5,x0,100
  - 7 onward: nop
- Required final state, within 15 cycles of reset release and stable thereafter: x1=10, x2=10, x4=0, x5=100. All other registers = 0.

Decomposition:
- Package riscv_pkg:
  - opcode/funct3/funct7 constants.
  - alu_op_e enum.
  - NOP constant.
  - pipeline-register structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t).
- Stage sub-blocks as a flat set. decode_stage (instance decode_stage_inst) is required and contains register_file (instance register_file_inst). Fetch, execute, memory and writeback may be inline logic in riscv_core.

Test Plan:
- Reset held 2 cycles, then released -> all registers 0 during reset. The ID/EX pipeline register holds a bubble. The fetched address after the first edge is 0.
- Run 25 cycles with the default ROM -> x1=32'd10, x2=32'd10, x4=32'd0, x5=32'd100; x3, x6..x31 = 0.
- Hazard check with a custom ROM: addi x1,x0,5 then immediately add x3,x1,x1 -> x3=0 (stale read, no forwarding). With two NOPs inserted -> x3=10.
- Branch: addi x1,x0,1; 2 nops; beq x1,x1,+12; addi x6,x0,7; addi x7,x0,7; addi x8,x0,9 -> x6=0, x7=0 (flushed), x8=9.
- Memory: addi x1,x0,42; 2 nops; sw x1,8(x0); lw x9,8(x0); 2 nops -> x9=42. Also addi x0,x0,5 -> x0 stays 0.
- Reset asserted mid-run (cycle 8) for 1 cycle -> registers clear immediately. The program re-executes and reaches the same final state.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings, ALU operations and pipeline-register layouts for riscv_core.
// PROGRAM images are packed with instruction word i at bits [32*i +: 32].
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int PROG_WORDS = 16;

  // Words 15..0, highest first: addi x1,10; addi x2,10; 3 nops; sub x4,x1,x2; addi x5,100.
  localparam logic [PROG_WORDS*32-1:0] DEFAULT_PROGRAM = {
    {9{NOP}}, 32'h0640_0293, 32'h4020_8233, {3{NOP}}, 32'h00A0_0113, 32'h00A0_0093
  };

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        bne;
    logic        jal;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  localparam if_id_t  IF_ID_BUBBLE  = '{pc: 32'd0, instr: NOP};
  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/riscv_core_decode.sv
// ID stage: field extraction, immediate generation and control decode.
// Unsupported encodings fall out of the case with all write enables low.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  if_id_t      if_id_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_wdata_i,
  output id_ex_t      id_ex_o
);

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val;

  assign instr  = if_id_i.instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

  register_file register_file_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val),
    .we_i     (wb_we_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_wdata_i)
  );

  always_comb begin
    id_ex_o         = ID_EX_BUBBLE;
    id_ex_o.pc      = if_id_i.pc;
    id_ex_o.rs1_val = rs1_val;
    id_ex_o.rs2_val = rs2_val;
    id_ex_o.rd      = rd;
    case (opcode)
      OP_LUI: begin
        id_ex_o.imm = imm_u; id_ex_o.use_imm = 1'b1;
        id_ex_o.alu_op = ALU_PASS_B; id_ex_o.reg_we = 1'b1;
      end
      OP_IMM: begin
        id_ex_o.imm = imm_i; id_ex_o.use_imm = 1'b1;
        id_ex_o.reg_we = 1'b1;
        case (funct3)
          F3_ADD:  id_ex_o.alu_op = ALU_ADD;
          F3_AND:  id_ex_o.alu_op = ALU_AND;
          F3_OR:   id_ex_o.alu_op = ALU_OR;
          F3_XOR:  id_ex_o.alu_op = ALU_XOR;
          F3_SLT:  id_ex_o.alu_op = ALU_SLT;
          default: id_ex_o.reg_we = 1'b0;
        endcase
      end
      OP_REG: begin
        id_ex_o.reg_we = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: id_ex_o.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}: id_ex_o.alu_op = ALU_SUB;
          {F7_BASE, F3_AND}: id_ex_o.alu_op = ALU_AND;
          {F7_BASE, F3_OR}:  id_ex_o.alu_op = ALU_OR;
          {F7_BASE, F3_XOR}: id_ex_o.alu_op = ALU_XOR;
          {F7_BASE, F3_SLT}: id_ex_o.alu_op = ALU_SLT;
          {F7_BASE, F3_SLL}: id_ex_o.alu_op = ALU_SLL;
          {F7_BASE, F3_SR}:  id_ex_o.alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:  id_ex_o.alu_op = ALU_SRA;
          default:           id_ex_o.reg_we = 1'b0;
        endcase
      end
      OP_LOAD: if (funct3 == F3_W) begin
        id_ex_o.imm = imm_i; id_ex_o.use_imm = 1'b1;
        id_ex_o.reg_we = 1'b1; id_ex_o.mem_re = 1'b1;
      end
      OP_STORE: if (funct3 == F3_W) begin
        id_ex_o.imm = imm_s; id_ex_o.use_imm = 1'b1;
        id_ex_o.mem_we = 1'b1;
      end
      OP_BRANCH: if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
        id_ex_o.imm = imm_b; id_ex_o.branch = 1'b1;
        id_ex_o.bne = (funct3 == F3_BNE);
      end
      OP_JAL: begin
        id_ex_o.imm = imm_j; id_ex_o.jal = 1'b1; id_ex_o.reg_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_core_regfile.sv
// 32x32 register file: x0 hardwired to zero, write on the WB clock edge,
// and write-through so a same-cycle read of the target sees the new value.
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] registers [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      registers[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = registers[raddr1_i];
    rdata2_o = registers[raddr2_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = '0;
    if (raddr2_i == 5'd0) rdata2_o = '0;
  end

endmodule

// File: rtl/riscv_core.sv
// 5-stage RV32I-subset pipeline with internal ROM and data RAM. No forwarding
// or interlock: software spaces dependent instructions; branches resolve in EX.
module riscv_core
  import riscv_pkg::*;
#(
  parameter int                        IMEM_DEPTH = 64,
  parameter int                        DMEM_DEPTH = 64,
  parameter logic [31:0]               RESET_PC   = 32'h0000_0000,
  parameter logic [PROG_WORDS*32-1:0]  PROGRAM    = DEFAULT_PROGRAM
) (
  input logic clk,
  input logic rst_n
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, id_decoded;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic [31:0] rom [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [IW-1:0] rom_idx;
  logic [DW-1:0] dmem_idx;
  logic [31:0] op_b, alu_res, target;
  logic        take;

  for (genvar g = 0; g < IMEM_DEPTH; g++) begin : g_rom
    if (g < PROG_WORDS) begin : g_prog
      assign rom[g] = PROGRAM[32*g +: 32];
    end else begin : g_fill
      assign rom[g] = NOP;
    end
  end

  assign rom_idx  = pc_q[IW+1:2];
  assign dmem_idx = ex_mem_q.result[DW+1:2];

  decode_stage decode_stage_inst (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_id_i    (if_id_q),
    .wb_we_i    (mem_wb_q.reg_we),
    .wb_rd_i    (mem_wb_q.rd),
    .wb_wdata_i (mem_wb_q.wdata),
    .id_ex_o    (id_decoded)
  );

  always_comb begin
    op_b = id_ex_q.use_imm ? id_ex_q.imm : id_ex_q.rs2_val;
    case (id_ex_q.alu_op)
      ALU_ADD:    alu_res = id_ex_q.rs1_val + op_b;
      ALU_SUB:    alu_res = id_ex_q.rs1_val - op_b;
      ALU_AND:    alu_res = id_ex_q.rs1_val & op_b;
      ALU_OR:     alu_res = id_ex_q.rs1_val | op_b;
      ALU_XOR:    alu_res = id_ex_q.rs1_val ^ op_b;
      ALU_SLT:    alu_res = {31'd0, $signed(id_ex_q.rs1_val) < $signed(op_b)};
      ALU_SLL:    alu_res = id_ex_q.rs1_val << op_b[4:0];
      ALU_SRL:    alu_res = id_ex_q.rs1_val >> op_b[4:0];
      ALU_SRA:    alu_res = $unsigned($signed(id_ex_q.rs1_val) >>> op_b[4:0]);
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
    target = id_ex_q.pc + id_ex_q.imm;
    take   = id_ex_q.jal ||
             (id_ex_q.branch && ((id_ex_q.rs1_val == id_ex_q.rs2_val) != id_ex_q.bne));
  end

  always_comb begin
    pc_d     = take ? target : pc_q + 32'd4;
    if_id_d  = take ? IF_ID_BUBBLE : '{pc: pc_q, instr: rom[rom_idx]};
    // A taken branch squashes both younger instructions behind it.
    id_ex_d  = take ? ID_EX_BUBBLE : id_decoded;
    ex_mem_d = '{result:    id_ex_q.jal ? id_ex_q.pc + 32'd4 : alu_res,
                 store_val: id_ex_q.rs2_val,
                 rd:        id_ex_q.rd,
                 reg_we:    id_ex_q.reg_we,
                 mem_re:    id_ex_q.mem_re,
                 mem_we:    id_ex_q.mem_we};
    mem_wb_d = '{wdata:  ex_mem_q.mem_re ? dmem[dmem_idx] : ex_mem_q.result,
                 rd:     ex_mem_q.rd,
                 reg_we: ex_mem_q.reg_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      if_id_q  <= IF_ID_BUBBLE;
      id_ex_q  <= ID_EX_BUBBLE;
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Data RAM holds its contents across reset.
  always_ff @(posedge clk) begin
    if (ex_mem_q.mem_we) dmem[dmem_idx] <= ex_mem_q.store_val;
  end

endmodule

// File: tb/tb_riscv_core.sv
// Runs the default program and four custom ROM images side by side, then
// compares architectural register state against expected-value queues.
module tb_riscv_core;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [6:0]  OPI = 7'b0010011, OPR = 7'b0110011, OPL = 7'b0000011;
  localparam logic [6:0]  OPS = 7'b0100011, OPB = 7'b1100011;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  localparam logic [511:0] PROG_HZ0 = {{14{NOP_W}},
    enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd3, OPR), enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI)};
  localparam logic [511:0] PROG_HZ2 = {{12{NOP_W}},
    enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd3, OPR), NOP_W, NOP_W, enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI)};
  localparam logic [511:0] PROG_BR = {{9{NOP_W}},
    enc_i(12'd9, 5'd0, 3'd0, 5'd8, OPI), enc_i(12'd7, 5'd0, 3'd0, 5'd7, OPI),
    enc_i(12'd7, 5'd0, 3'd0, 5'd6, OPI), enc_b(13'd12, 5'd1, 5'd1, 3'd0, OPB),
    NOP_W, NOP_W, enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI)};
  localparam logic [511:0] PROG_MEM = {{8{NOP_W}},
    enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI), NOP_W, NOP_W,
    enc_i(12'd8, 5'd0, 3'd2, 5'd9, OPL), enc_s(12'd8, 5'd1, 5'd0, 3'd2, OPS),
    NOP_W, NOP_W, enc_i(12'd42, 5'd0, 3'd0, 5'd1, OPI)};

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_core dut     (.clk(clk), .rst_n(rst_n));
  riscv_core #(.PROGRAM(PROG_HZ0)) dut_hz0 (.clk(clk), .rst_n(rst_n));
  riscv_core #(.PROGRAM(PROG_HZ2)) dut_hz2 (.clk(clk), .rst_n(rst_n));
  riscv_core #(.PROGRAM(PROG_BR))  dut_br  (.clk(clk), .rst_n(rst_n));
  riscv_core #(.PROGRAM(PROG_MEM)) dut_mem (.clk(clk), .rst_n(rst_n));

  function automatic logic [31:0] get_reg(int which, logic [4:0] idx);
    case (which)
      1:       return dut_hz0.decode_stage_inst.register_file_inst.registers[idx];
      2:       return dut_hz2.decode_stage_inst.register_file_inst.registers[idx];
      3:       return dut_br.decode_stage_inst.register_file_inst.registers[idx];
      4:       return dut_mem.decode_stage_inst.register_file_inst.registers[idx];
      default: return dut.decode_stage_inst.register_file_inst.registers[idx];
    endcase
  endfunction

  task automatic push_regs(logic [31:0] v1, logic [31:0] v2, logic [31:0] v3, logic [31:0] v4,
                           logic [31:0] v5, logic [31:0] v8, logic [31:0] v9);
    for (int i = 0; i < 32; i++) begin
      logic [4:0]  a = 5'(i);
      logic [31:0] v = '0;
      case (i)
        1: v = v1; 2: v = v2; 3: v = v3; 4: v = v4; 5: v = v5; 8: v = v8; 9: v = v9;
        default: v = '0;
      endcase
      exp_q.push_back({a, v});
    end
  endtask

  task automatic test_reset();
    logic [36:0] e;
    logic [31:0] got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    push_regs(0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = get_reg(0, e[36:32]);
      checks++;
      if (got !== e[31:0]) begin
        errors++;
        $display("FAIL reset_reg x%0d: got %h want %h", e[36:32], got, e[31:0]);
      end
    end
    checks++;
    if ({dut.id_ex_q.reg_we, dut.id_ex_q.mem_we, dut.id_ex_q.branch, dut.id_ex_q.jal} !== 4'b0) begin
      errors++;
      $display("FAIL reset_id_ex_bubble: got ctrl %b want 0000",
               {dut.id_ex_q.reg_we, dut.id_ex_q.mem_we, dut.id_ex_q.branch, dut.id_ex_q.jal});
    end
    checks++;
    if (dut.pc_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_pc: got %h want 00000000", dut.pc_q);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dut.if_id_q.pc !== 32'd0 || dut.if_id_q.instr !== 32'h00A0_0093) begin
      errors++;
      $display("FAIL first_fetch: got pc %h instr %h want pc 00000000 instr 00a00093",
               dut.if_id_q.pc, dut.if_id_q.instr);
    end
    checks++;
    if (dut.pc_q !== 32'd4) begin
      errors++;
      $display("FAIL pc_after_first_edge: got %h want 00000004", dut.pc_q);
    end
  endtask

  task automatic drain(int which, string name);
    logic [36:0] e;
    logic [31:0] got;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = get_reg(which, e[36:32]);
      checks++;
      if (got !== e[31:0]) begin
        errors++;
        $display("FAIL %s x%0d: got %h want %h", name, e[36:32], got, e[31:0]);
      end
    end
  endtask

  task automatic test_default_program();
    push_regs(32'd10, 32'd10, 0, 32'd10 - 32'd10, 32'd100, 0, 0);
    repeat (24) @(negedge clk);
    drain(0, "default_prog");
  endtask

  task automatic test_hazard();
    push_regs(32'd5, 0, 0, 0, 0, 0, 0);
    drain(1, "hazard_stale");
    push_regs(32'd5, 0, 32'd10, 0, 0, 0, 0);
    drain(2, "hazard_spaced");
  endtask

  task automatic test_branch();
    push_regs(32'd1, 0, 0, 0, 0, 32'd9, 0);
    drain(3, "branch_flush");
  endtask

  task automatic test_memory();
    push_regs(32'd42, 0, 0, 0, 0, 0, 32'd42);
    drain(4, "mem_sw_lw");
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back({5'd1, 32'd10});
    exp_q.push_back({5'd2, 32'd10});
    drain(0, "pre_reset");
    rst_n = 1'b0;
    #1;
    push_regs(0, 0, 0, 0, 0, 0, 0);
    drain(0, "mid_reset_clear");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    push_regs(32'd10, 32'd10, 0, 0, 32'd100, 0, 0);
    drain(0, "rerun_final");
  endtask

  initial begin
    test_reset();
    test_default_program();
    test_hazard();
    test_branch();
    test_memory();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
